// File: rtl/anim_pkg.sv
// Shared definitions for the sprite animation sequencer: animation ids,
// per-animation frame counts, FSM state encoding and a last-frame lookup.
package anim_pkg;

  typedef logic [1:0] anim_id_t;

  // Animation ids double as priorities: a larger id pre-empts a smaller one.
  localparam anim_id_t ANIM_IDLE   = 2'd0;
  localparam anim_id_t ANIM_WALK   = 2'd1;
  localparam anim_id_t ANIM_ATTACK = 2'd2;
  localparam anim_id_t ANIM_HURT   = 2'd3;

  // Number of frames stored in each sprite memory.
  localparam int unsigned FRAMES_IDLE   = 2;
  localparam int unsigned FRAMES_WALK   = 4;
  localparam int unsigned FRAMES_ATTACK = 6;
  localparam int unsigned FRAMES_HURT   = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  // Index of the final frame of an animation (frame count minus one).
  function automatic int unsigned frame_last(input anim_id_t anim);
    int unsigned last;
    case (anim)
      ANIM_IDLE:   last = FRAMES_IDLE - 1;
      ANIM_WALK:   last = FRAMES_WALK - 1;
      ANIM_ATTACK: last = FRAMES_ATTACK - 1;
      default:     last = FRAMES_HURT - 1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/anim_ctrl_if.sv
// Request handshake from game logic plus the (anim_sel, frame) pair that
// drives the sprite memory read path.
interface anim_ctrl_if
  import anim_pkg::*;
#(
  parameter int FRAME_W = 4
);
  logic               req_valid;
  anim_id_t           req_anim;
  logic               req_ready;
  anim_id_t           anim_sel;
  logic [FRAME_W-1:0] frame;
  logic               busy;
  logic               done;

  // Requester / sprite-memory side.
  modport master (
    output req_valid, req_anim,
    input  req_ready, anim_sel, frame, busy, done
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_anim,
    output req_ready, anim_sel, frame, busy, done
  );
endinterface

// File: rtl/anim_tick.sv
// Free-running frame prescaler: one tick every 2^DIV_W cycles, restartable
// so a new animation always gets a full-length first frame.
module anim_tick #(
  parameter int DIV_W = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Next count: restart on clear, otherwise wrap-around increment.
  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clr) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = &count_q;

endmodule

// File: rtl/anim_ctrl.sv
// Sprite animation sequencer: loops idle, plays one-shot animations on
// request with priority pre-emption, steps frames on prescaler ticks.
module anim_ctrl
  import anim_pkg::*;
#(
  parameter int DIV_W   = 23,
  parameter int FRAME_W = 4
) (
  input logic        clk,
  input logic        rst,
  anim_ctrl_if.slave bus
);

  state_t             state_q,    state_d;
  anim_id_t           anim_sel_q, anim_sel_d;
  logic [FRAME_W-1:0] frame_q,    frame_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  logic req_ready;
  logic accept;
  logic tick;

  // A request is takeable when idling or when it outranks the running
  // one-shot; an idle request never changes anything.
  always_comb begin
    req_ready = (state_q == S_IDLE) || (bus.req_anim > anim_sel_q);
    accept    = bus.req_valid && req_ready && (bus.req_anim != ANIM_IDLE);
  end

  // Restarting the prescaler on accept gives the new first frame its full hold.
  anim_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick)
  );

  // Next-state logic: accept beats tick; final tick of a one-shot returns to idle.
  always_comb begin
    state_d    = state_q;
    anim_sel_d = anim_sel_q;
    frame_d    = frame_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (accept) begin
      state_d    = S_PLAY;
      anim_sel_d = bus.req_anim;
      frame_d    = '0;
      busy_d     = 1'b1;
    end else if (tick) begin
      if (state_q == S_IDLE) begin
        if (frame_q == FRAME_W'(frame_last(ANIM_IDLE))) begin
          frame_d = '0;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end else if (frame_q == FRAME_W'(frame_last(anim_sel_q))) begin
        state_d    = S_IDLE;
        anim_sel_d = ANIM_IDLE;
        frame_d    = '0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  // State and output registers; anim_sel and frame always update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      anim_sel_q <= ANIM_IDLE;
      frame_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      anim_sel_q <= anim_sel_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.anim_sel  = anim_sel_q;
  assign bus.frame     = frame_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/anim_ctrl.md
# anim_ctrl

Sprite animation sequencer that produces the animation-select and frame-index pair consumed by the sprite frame memories (the idle/walk/attack/hurt pixel lookups). It replaces free-running divided-clock frame stepping with a single-clock, tick-enabled state machine. It loops the idle animation by default and plays one-shot animations on request, with priority pre-emption. It sits between game logic (requesters) and the sprite memory read path.

## Interface
- DIV_W, 23, prescaler width; one frame tick every 2^DIV_W clk cycles
- FRAME_W, 4, width of frame index
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  animation request strobe
- req_anim  in  2  requested animation: 0 idle, 1 walk, 2 attack, 3 hurt
- req_ready  out  1  request would be accepted this cycle (combinational)
- anim_sel  out  2  animation currently driven to sprite memory
- frame  out  FRAME_W  frame index within anim_sel
- busy  out  1  one-shot animation in progress
- done  out  1  one-cycle pulse when a one-shot animation completes

## Operation
- Frame counts (package constants): idle 2, walk 4, attack 6, hurt 3.
- Priority: hurt(3) > attack(2) > walk(1) > idle(0).
- States: S_IDLE (looping idle), S_PLAY (one-shot).
- req_ready = (state == S_IDLE) or (req_anim priority strictly greater than anim_sel). Combinational from state, anim_sel and req_anim; independent of req_valid.
- Accept = req_valid & req_ready & (req_anim != 0).
- On accept, the next cycle has:
  - state = S_PLAY
  - anim_sel = req_anim
  - frame = 0
  - prescaler = 0
  - busy = 1
- req_valid with req_anim = 0: req_ready may be 1, but there is no state change and frame/prescaler are not disturbed.
- Prescaler: DIV_W-bit up-counter that wraps. tick = (count == all-ones).
- S_IDLE on tick: frame increments; after frame 1 it wraps to 0.
- S_PLAY on tick, frame < count-1: frame increments.
- S_PLAY on tick, frame == count-1: next cycle has state = S_IDLE, anim_sel = 0, frame = 0, busy = 0, done = 1 for exactly one cycle.
- Accept and tick in the same cycle: accept wins; the tick is discarded.
- Accept in the same cycle as the final tick of a one-shot: accept wins, done is not pulsed, and the new animation starts at frame 0.
- Same-priority or lower-priority request during S_PLAY: req_ready = 0; the request is ignored and not queued.
- rst, including mid-animation: next cycle has state = S_IDLE, anim_sel = 0, frame = 0, prescaler = 0, busy = 0, done = 0. rst overrides accept.

## Timing
- Reset value of all outputs: anim_sel 0, frame 0, busy 0, done 0. req_ready is 1 after reset (S_IDLE).
- Accept-to-output latency: 1 cycle (registered outputs).
- Each frame is held for exactly 2^DIV_W cycles after accept or reset.
- A one-shot of N frames occupies N*2^DIV_W cycles from the accept edge to the done pulse.
- anim_sel and frame change only on the same edge, so sprite memory never sees a mismatched pair.

## Structure
- Package anim_pkg holds:
  - anim id constants (ANIM_IDLE = 0, ANIM_WALK = 1, ANIM_ATTACK = 2, ANIM_HURT = 3)
  - frame-count constants
  - function frame_last(anim) returning count-1
  - state encoding for S_IDLE/S_PLAY
- One sub-module, anim_tick: DIV_W prescaler with synchronous clear input and tick output. It is cleared by rst or accept.
- The remaining FSM, frame counter and output registers live in anim_ctrl.

## Test plan
All scenarios use DIV_W = 3 (tick every 8 cycles).
- Reset then free-run 40 cycles -> anim_sel 0; frame sequence 0,1,0,1,0 changing every 8 cycles; busy 0; done never asserted.
- Request attack (req_anim 2) in S_IDLE -> next cycle anim_sel 2, frame 0, busy 1; frames 0..5 held 8 cycles each; done pulses once 48 cycles after accept; then anim_sel 0, frame 0, busy 0.
- During walk, at frame 2, request hurt -> req_ready 1; next cycle anim_sel 3, frame 0. Hurt runs 24 cycles, then one done pulse and no walk resumption.
- During attack, request walk or attack -> req_ready 0; anim_sel/frame unaffected; done occurs at the original time.
- Request hurt on the exact cycle of the final attack tick -> no done pulse; anim_sel 3, frame 0 next cycle; tick and accept in the same cycle: frame 0, not incremented.
- Assert rst at walk frame 3 -> next cycle anim_sel 0, frame 0, busy 0, done 0; first idle advance occurs 8 cycles after rst deasserts.
